maxpool_quant_pack: RTL and testbench



---
 rtl/maxpool_pkg.sv | 19 +
 rtl/maxpool_quant_pack_fifo.sv | 70 +++++++
 rtl/maxpool_quant_pack.sv | 204 ++++++++++++++++++++
 tb/tb_maxpool_quant_pack.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maxpool_pkg.sv
// Shared definitions for the max-pool requantize/pack stage: widths, FIFO depth,
// FSM states and the signed 8-bit saturation bounds.
package maxpool_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int OUT_W_DEF  = 8;
    localparam int PACK_DEF   = 4;
    localparam int FIFO_DEPTH = 4;

    localparam int Q_MAX = 127;
    localparam int Q_MIN = -128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/maxpool_quant_pack_fifo.sv
// word_fifo4: synchronous show-ahead FIFO for packed activation words, with
// occupancy output so the producer can throttle upstream early.
module word_fifo4
    import maxpool_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_push,
    input  logic [WIDTH-1:0]                 i_din,
    input  logic                             i_pop,
    output logic [WIDTH-1:0]                 o_dout,
    output logic                             o_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  o_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH+1);

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    // A push into a full FIFO is only taken when the head leaves on the same edge.
    assign do_pop  = i_pop && (cnt_q != '0);
    assign do_push = i_push && ((cnt_q != CW'(FIFO_DEPTH)) || do_pop);

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            mem_d[wr_q] = i_din;
            wr_d        = wr_q + AW'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign o_dout  = mem_q[rd_q];
    assign o_valid = (cnt_q != '0);
    assign o_count = cnt_q;

endmodule

// File: rtl/maxpool_quant_pack.sv
// Pooling-window sequencer, requantizer (shift/round/saturate) and word packer
// feeding a 4-deep output FIFO. Define POOL_RELU_EN to clamp negatives to zero.
module maxpool_quant_pack
    import maxpool_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int PACK   = PACK_DEF
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_start,
    input  logic                      i_maxpool,
    input  logic [4:0]                i_win_size,
    input  logic [4:0]                i_shift,
    input  logic                      i_res_valid,
    output logic                      o_in_ready,
    output logic                      o_max_rst,
    output logic                      o_maxpool,
    input  logic signed [DATA_W-1:0]  i_max,
    input  logic                      i_flush,
    output logic [PACK*OUT_W-1:0]     o_word,
    output logic                      o_word_valid,
    input  logic                      i_word_ready,
    output logic                      o_done
);

    localparam int WW  = PACK * OUT_W;
    localparam int PCW = $clog2(PACK);
    localparam int OCW = $clog2(FIFO_DEPTH+1);

    state_e           state_q, state_d;
    logic             maxpool_q, maxpool_d;
    logic [4:0]       win_q, win_d;
    logic [4:0]       shift_q, shift_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             sample_q, sample_d;
    logic [WW-1:0]    pack_q, pack_d;
    logic [PCW-1:0]   pcnt_q, pcnt_d;
    logic             done_q, done_d;

    logic             accept, win_last, push, pop, fifo_room;
    logic [WW-1:0]    push_word, merged;
    logic [OUT_W-1:0] q_byte;
    logic [OCW-1:0]   occ;

    function automatic logic [OUT_W-1:0] saturate(input logic signed [DATA_W:0] t);
        logic signed [DATA_W:0] v;
        logic [OUT_W-1:0]       r;
        v = t;
`ifdef POOL_RELU_EN
        if (v < 0) v = '0;
`endif
        if (v > (DATA_W+1)'(Q_MAX))      r = OUT_W'(Q_MAX);
        else if (v < (DATA_W+1)'(Q_MIN)) r = OUT_W'(Q_MIN);
        else                             r = v[OUT_W-1:0];
        return r;
    endfunction

    // Round-half-up arithmetic shift in one extra bit so the rounding add cannot overflow.
    function automatic logic [OUT_W-1:0] requant(input logic signed [DATA_W-1:0] x,
                                                 input logic [4:0] s);
        logic signed [DATA_W:0] ext, rnd, sum, t;
        ext = (DATA_W+1)'(x);
        rnd = '0;
        sum = ext;
        if (s == 5'd0) begin
            t = ext;
        end else begin
            rnd = (DATA_W+1)'(1) <<< (s - 5'd1);
            sum = ext + rnd;
            t   = sum >>> s;
        end
        return saturate(t);
    endfunction

    assign o_in_ready = (state_q == RUN) && (occ <= OCW'(FIFO_DEPTH-2));
    assign accept     = i_res_valid && o_in_ready;
    assign win_last   = (cnt_q == win_q - 5'd1);
    assign o_max_rst  = accept && (!maxpool_q || (cnt_q == 5'd0));
    assign pop        = o_word_valid && i_word_ready;
    assign fifo_room  = (occ != OCW'(FIFO_DEPTH)) || pop;
    assign q_byte     = requant(i_max, shift_q);

    always_comb begin
        merged = pack_q;
        merged[pcnt_q*OUT_W +: OUT_W] = q_byte;
    end

    always_comb begin
        state_d   = state_q;
        maxpool_d = maxpool_q;
        win_d     = win_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        sample_d  = 1'b0;
        pack_d    = pack_q;
        pcnt_d    = pcnt_q;
        done_d    = 1'b0;
        push      = 1'b0;
        push_word = merged;

        unique case (state_q)
            IDLE: begin
            end
            RUN: begin
                if (sample_q) begin
                    if (pcnt_q == PCW'(PACK-1)) begin
                        push   = 1'b1;
                        pack_d = '0;
                        pcnt_d = '0;
                    end else begin
                        pack_d = merged;
                        pcnt_d = pcnt_q + PCW'(1);
                    end
                end
                if (accept) begin
                    if (!maxpool_q || win_last) begin
                        cnt_d    = '0;
                        sample_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                if (i_flush) state_d = FLUSH;
            end
            FLUSH: begin
                // A late sample is merged and pushed padded in the same cycle.
                if (sample_q) begin
                    push    = 1'b1;
                    pack_d  = '0;
                    pcnt_d  = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (pcnt_q == '0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (fifo_room) begin
                    push      = 1'b1;
                    push_word = pack_q;
                    pack_d    = '0;
                    pcnt_d    = '0;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (i_start) begin
            maxpool_d = i_maxpool;
            win_d     = (i_win_size == 5'd0) ? 5'd1 : i_win_size;
            shift_d   = i_shift;
            cnt_d     = '0;
            sample_d  = 1'b0;
            pack_d    = '0;
            pcnt_d    = '0;
            done_d    = 1'b0;
            push      = 1'b0;
            state_d   = RUN;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            maxpool_q <= 1'b0;
            win_q     <= 5'd1;
            shift_q   <= '0;
            cnt_q     <= '0;
            sample_q  <= 1'b0;
            pack_q    <= '0;
            pcnt_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            maxpool_q <= maxpool_d;
            win_q     <= win_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            sample_q  <= sample_d;
            pack_q    <= pack_d;
            pcnt_q    <= pcnt_d;
            done_q    <= done_d;
        end
    end

    assign o_maxpool = maxpool_q;
    assign o_done    = done_q;

    word_fifo4 #(
        .WIDTH (WW)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_din   (push_word),
        .i_pop   (pop),
        .o_dout  (o_word),
        .o_valid (o_word_valid),
        .o_count (occ)
    );

endmodule

// File: tb/tb_maxpool_quant_pack.sv
// Directed + randomized bench for maxpool_quant_pack with a behavioural compare
// register, requant reference and word scoreboard.
module tb_maxpool_quant_pack;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic               start;
    logic               maxpool_in;
    logic [4:0]         win;
    logic [4:0]         shift;
    logic               res_valid;
    logic signed [31:0] res;
    logic               in_ready;
    logic               max_rst;
    logic               maxpool_out;
    logic signed [31:0] max_val = '0;
    logic               flush;
    logic [31:0]        word;
    logic               word_valid;
    logic               word_ready;
    logic               done;

    maxpool_quant_pack dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_maxpool    (maxpool_in),
        .i_win_size   (win),
        .i_shift      (shift),
        .i_res_valid  (res_valid),
        .o_in_ready   (in_ready),
        .o_max_rst    (max_rst),
        .o_maxpool    (maxpool_out),
        .i_max        (max_val),
        .i_flush      (flush),
        .o_word       (word),
        .o_word_valid (word_valid),
        .i_word_ready (word_ready),
        .o_done       (done)
    );

    // Compare register stand-in: loads on max_rst, keeps the running maximum of accepted results.
    always @(posedge clk) begin
        if (max_rst) max_val <= res;
        else if (maxpool_out && res_valid && in_ready && (res > max_val)) max_val <= res;
    end

    int errs = 0;
    int checks = 0;
    logic [31:0] expq[$];
    logic [7:0]  pend[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_q(input longint x, input int s);
        longint t;
        if (s == 0) t = x;
        else t = (x + (longint'(1) << (s - 1))) >>> s;
`ifdef POOL_RELU_EN
        if (t < 0) t = 0;
`endif
        if (t > 127) t = 127;
        if (t < -128) t = -128;
        return t[7:0];
    endfunction

    task automatic push_byte(input logic [7:0] b);
        logic [31:0] w;
        pend.push_back(b);
        if (pend.size() == 4) begin
            w = {pend[3], pend[2], pend[1], pend[0]};
            expq.push_back(w);
            pend.delete();
        end
    endtask

    task automatic flush_model();
        logic [31:0] w;
        if (pend.size() > 0) begin
            w = '0;
            for (int i = 0; i < pend.size(); i++) w[i*8 +: 8] = pend[i];
            expq.push_back(w);
            pend.delete();
        end
    endtask

    task automatic wordmon();
        logic [31:0] e;
        if (word_valid && word_ready) begin
            if (expq.size() == 0) begin
                check("extra_word", 64'(word), 64'hDEAD_0000_0000);
            end else begin
                e = expq.pop_front();
                check("word", 64'(word), 64'(e));
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        wordmon();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [31:0] v, output logic mr);
        logic got;
        got = 1'b0;
        mr = 1'b0;
        res = v;
        res_valid = 1'b1;
        for (int k = 0; k < 500 && !got; k++) begin
            @(negedge clk);
            wordmon();
            got = in_ready;
            mr = max_rst;
            @(posedge clk);
            #1;
        end
        if (!got) check("accept_timeout", 64'(got), 64'd1);
    endtask

    task automatic pulse_start(input logic mp, input logic [4:0] w, input logic [4:0] s);
        maxpool_in = mp;
        win = w;
        shift = s;
        start = 1'b1;
        cyc();
        start = 1'b0;
        pend.delete();
    endtask

    initial begin
        logic mr;
        logic signed [31:0] mx, v;
        logic signed [31:0] t1v[4];
        logic signed [31:0] t2v[4];
        int acc, sh, wsz, weff, nwin;

        rst_n = 1'b0; start = 1'b0; maxpool_in = 1'b0; win = '0; shift = '0;
        res_valid = 1'b0; res = '0; flush = 1'b0; word_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 0);
        check("rst_word_valid", 64'(word_valid), 0);
        check("rst_word", 64'(word), 0);
        check("rst_done", 64'(done), 0);
        check("rst_maxpool", 64'(maxpool_out), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc();

        // Max-pool, win=4, shift=0: four windows of 5,-3,9,2
        t1v = '{32'sd5, -32'sd3, 32'sd9, 32'sd2};
        pulse_start(1'b1, 5'd4, 5'd0);
        check("t1_maxpool", 64'(maxpool_out), 1);
        word_ready = 1'b0;
        for (int w = 0; w < 4; w++) begin
            mx = 32'sh8000_0000;
            for (int e = 0; e < 4; e++) begin
                send(t1v[e], mr);
                check("t1_max_rst", 64'(mr), 64'(e == 0));
                if (t1v[e] > mx) mx = t1v[e];
            end
            push_byte(ref_q(mx, 0));
        end
        res_valid = 1'b0;
        @(negedge clk);
        check("t1_valid_t1", 64'(word_valid), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_valid_t2", 64'(word_valid), 1);
        check("t1_word", 64'(word), 64'h0909_0909);
        @(posedge clk); #1;
        word_ready = 1'b1;
        repeat (3) cyc();
        check("t1_drained", 64'(expq.size()), 0);

        // Passthrough, shift=4
        t2v = '{32'sh100, 32'sh108, 32'sh7FFF, -32'sh7FFF};
        pulse_start(1'b0, 5'd1, 5'd4);
        check("t2_maxpool", 64'(maxpool_out), 0);
        word_ready = 1'b0;
        for (int e = 0; e < 4; e++) begin
            send(t2v[e], mr);
            check("t2_max_rst", 64'(mr), 1);
            push_byte(ref_q(t2v[e], 4));
        end
        res_valid = 1'b0;
        repeat (2) cyc();
        @(negedge clk);
        check("t2_valid", 64'(word_valid), 1);
`ifdef POOL_RELU_EN
        check("t2_word", 64'(word), 64'h007F_1110);
`else
        check("t2_word", 64'(word), 64'h807F_1110);
`endif
        @(posedge clk); #1;
        word_ready = 1'b1;
        repeat (3) cyc();
        check("t2_drained", 64'(expq.size()), 0);

        // win=2, maxes 1,2,3 then flush of a partial pack
        pulse_start(1'b1, 5'd2, 5'd0);
        send(32'sd1, mr); send(32'sd0, mr); push_byte(8'd1);
        send(32'sd2, mr); send(-32'sd5, mr); push_byte(8'd2);
        send(32'sd3, mr); send(32'sd3, mr); push_byte(8'd3);
        res_valid = 1'b0;
        flush = 1'b1;
        flush_model();
        @(negedge clk);
        check("t3_done_f0", 64'(done), 0);
        wordmon();
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("t3_done_f1", 64'(done), 0);
        wordmon();
        @(posedge clk); #1;
        @(negedge clk);
        check("t3_done_f2", 64'(done), 1);
        check("t3_valid", 64'(word_valid), 1);
        check("t3_word", 64'(word), 64'h0003_0201);
        wordmon();
        @(posedge clk); #1;
        @(negedge clk);
        check("t3_done_f3", 64'(done), 0);
        check("t3_empty", 64'(word_valid), 0);
        @(posedge clk); #1;

        // Flush with empty pack: o_done only
        pulse_start(1'b1, 5'd2, 5'd0);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        cyc();
        @(negedge clk);
        check("t3e_done", 64'(done), 1);
        check("t3e_no_word", 64'(word_valid), 0);
        check("t3e_idle", 64'(in_ready), 0);
        @(posedge clk); #1;

        // Output stall with continuous valid
        sh = int'($urandom_range(0, 31));
        pulse_start(1'b0, 5'd1, 5'(sh));
        word_ready = 1'b0;
        acc = 0;
        res = $urandom;
        res_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (in_ready) begin
                acc++;
                push_byte(ref_q(res, sh));
                @(posedge clk); #1;
                res = $urandom;
            end else begin
                @(posedge clk); #1;
            end
        end
        check("t4_accepts", 64'(acc), 13);
        @(negedge clk);
        check("t4_ready_low", 64'(in_ready), 0);
        check("t4_valid", 64'(word_valid), 1);
        @(posedge clk); #1;
        word_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            v = $urandom;
            send(v, mr);
            push_byte(ref_q(v, sh));
        end
        res_valid = 1'b0;
        flush = 1'b1;
        flush_model();
        cyc();
        flush = 1'b0;
        repeat (10) cyc();
        check("t4_drained", 64'(expq.size()), 0);

        // Randomized max-pool windows
        for (int r = 0; r < 4; r++) begin
            wsz = int'($urandom_range(0, 16));
            weff = (wsz == 0) ? 1 : wsz;
            sh = int'($urandom_range(0, 31));
            nwin = int'($urandom_range(3, 9));
            pulse_start(1'b1, 5'(wsz), 5'(sh));
            for (int w = 0; w < nwin; w++) begin
                mx = 32'sh8000_0000;
                for (int e = 0; e < weff; e++) begin
                    v = $signed($urandom) >>> $urandom_range(0, 31);
                    send(v, mr);
                    check("rnd_max_rst", 64'(mr), 64'(e == 0));
                    if (v > mx) mx = v;
                end
                push_byte(ref_q(mx, sh));
            end
            res_valid = 1'b0;
            flush = 1'b1;
            flush_model();
            cyc();
            flush = 1'b0;
            repeat (8) cyc();
            check("rnd_drained", 64'(expq.size()), 0);
        end

        // Restart mid-window drops the partial pack
        pulse_start(1'b1, 5'd4, 5'd0);
        send(32'sd4, mr); send(32'sd7, mr); send(32'sd1, mr); send(32'sd0, mr);
        push_byte(8'd7);
        send(32'sd11, mr); send(32'sd12, mr);
        res_valid = 1'b0;
        repeat (2) cyc();
        pulse_start(1'b1, 5'd4, 5'd0);
        for (int w = 0; w < 4; w++) begin
            send(32'(w), mr);
            if (w == 0) check("t5_restart_max_rst", 64'(mr), 1);
            send(-32'(w), mr);
            send(32'(20 + w), mr);
            send(32'sd3, mr);
            push_byte(8'(20 + w));
        end
        res_valid = 1'b0;
        repeat (5) cyc();
        check("t5_drained", 64'(expq.size()), 0);

        // Reset with three words queued
        pulse_start(1'b0, 5'd1, 5'd0);
        word_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            send(32'(i), mr);
            push_byte(8'(i));
        end
        res_valid = 1'b0;
        repeat (4) cyc();
        @(negedge clk);
        check("t6_queued", 64'(word_valid), 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_valid", 64'(word_valid), 0);
        check("t6_word", 64'(word), 0);
        check("t6_in_ready", 64'(in_ready), 0);
        check("t6_max_rst", 64'(max_rst), 0);
        check("t6_done", 64'(done), 0);
        check("t6_maxpool", 64'(maxpool_out), 0);
        expq.delete();
        pend.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        word_ready = 1'b1;
        repeat (2) cyc();
        @(negedge clk);
        check("t6_post_valid", 64'(word_valid), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
